spraid_stripe_sched: RTL and testbench
======================================

SPRAID_STRIPE_SCHED -- requirements
Module: spraid_stripe_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the watchdog limit in wb_clk_i cycles per stripe transfer; legal range 2..65535.
REQ-002 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 cmd_valid  in  1  stripe command request.
REQ-005 cmd_ready  out  1  scheduler accepts a command; a command is accepted when cmd_valid and cmd_ready are both high.
REQ-006 cmd_wdata  in  32  write word; byte lane i (bits 8i+7:8i) goes to SPI channel i.
REQ-007 cmd_chmask  in  4  channel enable; bit i set means channel i takes part.
REQ-008 spi_start  out  4  one-cycle start pulse per SPI byte engine.
REQ-009 spi_tx_byte  out  32  packed transmit bytes, lane i to engine i.
REQ-010 spi_done  in  4  one-cycle completion pulse per engine.
REQ-011 spi_rx_byte  in  32  packed receive bytes; lane i is valid while spi_done[i] is high.
REQ-012 rsp_valid  out  1  response available.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-014 rsp_rdata  out  32  assembled receive word.
REQ-015 rsp_err  out  1  transfer ended by timeout.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: cmd_ready=1; on accept, latch cmd_wdata to spi_tx_byte and cmd_chmask to mask; go to ISSUE, or go directly to RESP with rdata=0 and err=0 when the mask is 0.
REQ-019 ISSUE: spi_start=mask for exactly one cycle; clear done_seen, the rx capture register and the timer; go to WAIT.
REQ-020 WAIT: on each cycle, for each i with spi_done[i]&mask[i], set done_seen[i] and capture spi_rx_byte lane i; go to RESP on the cycle after done_seen==mask, with err=0.
REQ-021 spi_done pulses on unmasked channels, and pulses outside WAIT, SHALL be ignored; a repeated pulse on a channel already done SHALL overwrite that captured lane.
REQ-022 rsp_rdata lanes of unmasked channels SHALL be 0; rsp_rdata, rsp_err and busy SHALL hold stable for as long as rsp_valid is high.
REQ-023 RESP: rsp_valid=1; on rsp_ready go to IDLE; a new command may be accepted no earlier than the cycle after that handshake.
REQ-024 spi_tx_byte SHALL hold the latched value from ISSUE until the next accept.
REQ-025 Minimum latency from accept to rsp_valid is 3 cycles, when all done pulses arrive on the first WAIT cycle.
REQ-026 cmd_ready and rsp_valid SHALL never be high in the same cycle.

Reset
REQ-027 While wb_rst_i is high at a clock edge, the FSM SHALL go to IDLE and these outputs SHALL be 0: cmd_ready (it rises on the first cycle after reset), spi_start, spi_tx_byte, rsp_valid, rsp_rdata, rsp_err, busy.
REQ-028 Reset asserted in any state, including mid-WAIT, SHALL abort the transfer with no response and no further spi_start pulse.

Configuration
REQ-029 Macro SPRAID_TIMEOUT_EN defined: a 16-bit timer counts in WAIT; when it reaches TIMEOUT_CYCLES-1 with done_seen!=mask, go to RESP with rsp_err=1 and the lanes captured so far (others 0).
REQ-030 If done_seen==mask and the timer limit occur in the same cycle, completion SHALL win and rsp_err SHALL be 0.
REQ-031 Macro undefined: no timer logic exists, rsp_err is tied to 0, and WAIT exits only on completion.

Verification
REQ-032 Full stripe: mask=4'hF, wdata=32'hA1B2C3D4; all engines pulse done 5 cycles after start with rx bytes 11,22,33,44 (lane 3..0) -> spi_tx_byte=32'hA1B2C3D4, single spi_start=4'hF pulse, rsp_rdata=32'h11223344, rsp_err=0.
REQ-033 Partial and staggered: mask=4'b0101; done[0] at +2, done[2] at +9, spurious done[1] at +4 -> response only after done[2], rsp_rdata has lanes 1 and 3 equal to 0.
REQ-034 Zero mask: mask=0 -> no spi_start; rsp_valid on the cycle after accept with rdata=0; hold rsp_ready low 3 cycles -> outputs stable, cmd_ready=0.
REQ-035 Timeout (SPRAID_TIMEOUT_EN, TIMEOUT_CYCLES=16): mask=4'hF, engine 3 never completes -> rsp_err=1 after 16 WAIT cycles, lane 3=0; repeat with done[3] on the limit cycle -> rsp_err=0.
REQ-036 Reset mid-WAIT: assert wb_rst_i 3 cycles after spi_start -> all outputs 0 next cycle, late done pulses ignored, next command completes normally.

Source files
------------

// File: rtl/spraid_stripe_sched.sv
// spraid_stripe_sched: fans one 32-bit stripe command out to four SPI byte
// engines and gathers their receive bytes into one response word.
// Ports:
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_wdata lane i -> engine i,
//                           cmd_chmask bit i enables engine i
//   spi_start, spi_tx_byte  per-engine start pulse and transmit byte lanes
//   spi_done, spi_rx_byte   per-engine done pulse and receive byte lanes
//   rsp_valid/rsp_ready     response handshake; rsp_rdata assembled word,
//                           rsp_err set when the stripe timed out
//   busy                    high whenever the scheduler is not idle
// Build option: SPRAID_TIMEOUT_EN adds a watchdog of TIMEOUT_CYCLES wait
// cycles per stripe; without it rsp_err is constant 0.
module spraid_stripe_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_chmask,
   output logic [3:0]  spi_start,
   output logic [31:0] spi_tx_byte,
   input  logic [3:0]  spi_done,
   input  logic [31:0] spi_rx_byte,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  mask;
   logic [3:0]  done_seen;
   logic [3:0]  hit;
   logic [3:0]  seen_nxt;
   logic [31:0] tx_q;
   logic [31:0] rx_q;
   logic [31:0] rx_nxt;
   logic        accept;
   logic        done_all;
   logic        tmo;

   generate
      if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
         $error("TIMEOUT_CYCLES out of range 2..65535");
      end
   endgenerate

   assign accept      = cmd_valid & cmd_ready;
   assign hit         = spi_done & mask;
   assign spi_tx_byte = tx_q;
   assign rsp_rdata   = rx_q;

   // Pulses of the current cycle count toward completion, so all engines
   // finishing on the first wait cycle gives rsp_valid 3 cycles after accept.
   always_comb begin
      seen_nxt = done_seen | hit;
      rx_nxt   = rx_q;
      for (int i = 0; i < 4; i++) begin
         if (hit[i]) rx_nxt[8*i +: 8] = spi_rx_byte[8*i +: 8];
      end
   end

   assign done_all = (seen_nxt == mask);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      spi_start = 4'd0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            cmd_ready = ~wb_rst_i;
            if (cmd_valid && !wb_rst_i)
               state_nxt = (cmd_chmask == 4'd0) ? RESP : ISSUE;
         end
         ISSUE: begin
            spi_start = mask;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (done_all || tmo) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         mask      <= 4'd0;
         done_seen <= 4'd0;
         tx_q      <= 32'd0;
         rx_q      <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  tx_q <= cmd_wdata;
                  mask <= cmd_chmask;
                  rx_q <= 32'd0;
               end
            end
            ISSUE: begin
               done_seen <= 4'd0;
               rx_q      <= 32'd0;
            end
            WAIT: begin
               done_seen <= seen_nxt;
               rx_q      <= rx_nxt;
            end
            default: ;
         endcase
      end
   end

`ifdef SPRAID_TIMEOUT_EN
   localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] timer;
   logic        err_q;

   // A lane finishing on the limit cycle completes rather than timing out.
   assign tmo     = (state == WAIT) && (timer == LIMIT) && !done_all;
   assign rsp_err = err_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timer <= 16'd0;
         err_q <= 1'b0;
      end else begin
         if (state == ISSUE)     timer <= 16'd0;
         else if (state == WAIT) timer <= timer + 16'd1;
         if (accept)   err_q <= 1'b0;
         else if (tmo) err_q <= 1'b1;
      end
   end
`else
   assign tmo     = 1'b0;
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_spraid_stripe_sched.sv
// tb_spraid_stripe_sched: directed stripe commands against a transaction
// model of the scheduler, checked every cycle plus hand-computed results.
module tb_spraid_stripe_sched;

   localparam int TO = 16;
`ifdef SPRAID_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        wb_clk_i    = 1'b0;
   logic        wb_rst_i    = 1'b1;
   logic        cmd_valid   = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_wdata   = 32'd0;
   logic [3:0]  cmd_chmask  = 4'd0;
   logic [3:0]  spi_start;
   logic [31:0] spi_tx_byte;
   logic [3:0]  spi_done    = 4'd0;
   logic [31:0] spi_rx_byte = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready   = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   logic rst_q = 1'b0;

   // pulse schedule: offset in cycles after the spi_start cycle
   int         sch_n = 0;
   int         sch_off[8];
   int         sch_lane[8];
   logic [7:0] sch_val[8];

   bit          active   = 1'b0;
   int          acc_cyc  = 0;
   int          resp_cyc = 0;
   int          rc_tmp;
   logic        exp_rv;
   logic [3:0]  exp_mask = 4'd0;
   logic [31:0] exp_tx   = 32'd0;
   logic [31:0] exp_rd   = 32'd0;
   logic        exp_er   = 1'b0;

   int          obs_first  = -1;
   int          obs_hs     = 0;
   int          obs_starts = 0;
   int          obs_rvn    = 0;
   logic [31:0] obs_rd     = 32'd0;
   logic        obs_er     = 1'b0;

   spraid_stripe_sched #(.TIMEOUT_CYCLES(TO)) dut (
      .wb_clk_i    (wb_clk_i),
      .wb_rst_i    (wb_rst_i),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_wdata   (cmd_wdata),
      .cmd_chmask  (cmd_chmask),
      .spi_start   (spi_start),
      .spi_tx_byte (spi_tx_byte),
      .spi_done    (spi_done),
      .spi_rx_byte (spi_rx_byte),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .busy        (busy)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) begin
      cyc   <= cyc + 1;
      rst_q <= wb_rst_i;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Response timing and content from the stripe rules: a response comes the
   // cycle after every masked lane has pulsed once; the last pulse per lane
   // wins; unmasked lanes read 0; with the watchdog, wait cycle TO without
   // completion ends the stripe with err set.
   function automatic void predict(input logic [3:0] m, output int rc,
                                   output logic [31:0] rd, output logic er);
      logic [3:0] seen;
      seen = 4'd0;
      rd   = 32'd0;
      er   = 1'b0;
      rc   = -1;
      if (m == 4'd0) begin
         rc = 1;
         return;
      end
      for (int off = 1; off <= 300; off++) begin
         for (int j = 0; j < sch_n; j++) begin
            if (sch_off[j] == off && m[sch_lane[j]]) begin
               rd[8*sch_lane[j] +: 8] = sch_val[j];
               seen[sch_lane[j]] = 1'b1;
            end
         end
         if (seen == m) begin
            rc = off + 2;
            return;
         end
         if (TMO_EN && off == TO) begin
            er = 1'b1;
            rc = off + 2;
            return;
         end
      end
   endfunction

   always @(negedge wb_clk_i) begin
      if (cyc > 0) begin
         if (rst_q) begin
            active = 1'b0;
            exp_tx = 32'd0;
            chk("rst_cmd_ready", 32'(cmd_ready), 32'(!wb_rst_i));
            chk("rst_spi_start", 32'(spi_start), 32'd0);
            chk("rst_tx_byte", spi_tx_byte, 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rdata", rsp_rdata, 32'd0);
            chk("rst_err", 32'(rsp_err), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
         end else begin
            exp_rv = active && (cyc >= resp_cyc);
            chk("cmd_ready", 32'(cmd_ready), 32'(!active));
            chk("busy", 32'(busy), 32'(active));
            chk("spi_start", 32'(spi_start),
                (active && cyc == acc_cyc + 1) ? 32'(exp_mask) : 32'd0);
            chk("spi_tx_byte", spi_tx_byte, exp_tx);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("ready_valid_excl", 32'(cmd_ready & rsp_valid), 32'd0);
            if (exp_rv) begin
               chk("rsp_rdata", rsp_rdata, exp_rd);
               chk("rsp_err", 32'(rsp_err), 32'(exp_er));
            end
            if (active) begin
               if (spi_start != 4'd0) obs_starts++;
               if (rsp_valid) begin
                  obs_rvn++;
                  if (obs_first < 0) obs_first = cyc;
               end
               if (exp_rv && rsp_valid && rsp_ready) begin
                  obs_rd = rsp_rdata;
                  obs_er = rsp_err;
                  obs_hs++;
                  active = 1'b0;
               end
            end else if (cmd_valid && cmd_ready) begin
               active   = 1'b1;
               acc_cyc  = cyc;
               exp_mask = cmd_chmask;
               exp_tx   = cmd_wdata;
               predict(cmd_chmask, rc_tmp, exp_rd, exp_er);
               resp_cyc = (rc_tmp < 0) ? 32'h7fffffff : cyc + rc_tmp;
               obs_first  = -1;
               obs_starts = 0;
               obs_rvn    = 0;
            end
         end
      end
   end

   task automatic sch_clear();
      sch_n = 0;
   endtask

   task automatic sch_add(input int off, input int lane, input logic [7:0] v);
      sch_off[sch_n]  = off;
      sch_lane[sch_n] = lane;
      sch_val[sch_n]  = v;
      sch_n++;
   endtask

   // Returns at 1ns into the cycle after accept (the ISSUE cycle).
   task automatic issue(input logic [31:0] wd, input logic [3:0] m,
                        output int a);
      cmd_wdata  = wd;
      cmd_chmask = m;
      cmd_valid  = 1'b1;
      a = -1;
      for (int k = 0; k < 20 && a < 0; k++) begin
         @(negedge wb_clk_i);
         if (cmd_ready) a = cyc;
         @(posedge wb_clk_i);
         #1;
      end
      cmd_valid = 1'b0;
      chk("accept_seen", 32'(a >= 0), 32'd1);
   endtask

   task automatic pulses(input int n);
      for (int off = 1; off <= n; off++) begin
         @(posedge wb_clk_i);
         #1;
         spi_done    = 4'd0;
         spi_rx_byte = $urandom();
         for (int j = 0; j < sch_n; j++) begin
            if (sch_off[j] == off) begin
               spi_done[sch_lane[j]] = 1'b1;
               spi_rx_byte[8*sch_lane[j] +: 8] = sch_val[j];
            end
         end
      end
      @(posedge wb_clk_i);
      #1;
      spi_done = 4'd0;
   endtask

   task automatic wait_idle(input int lim);
      for (int k = 0; k < lim && active; k++) begin
         @(posedge wb_clk_i);
         #1;
      end
      chk("response_within_budget", 32'(active), 32'd0);
   endtask

   initial begin
      int a;
      int hs0;
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      @(posedge wb_clk_i);
      #1;

      // full stripe, all engines done 5 cycles after start
      sch_clear();
      sch_add(5, 0, 8'h44);
      sch_add(5, 1, 8'h33);
      sch_add(5, 2, 8'h22);
      sch_add(5, 3, 8'h11);
      issue(32'hA1B2C3D4, 4'hF, a);
      pulses(6);
      wait_idle(60);
      chk("full_latency", 32'(obs_first - a), 32'd7);
      chk("full_rdata", obs_rd, 32'h11223344);
      chk("full_err", 32'(obs_er), 32'd0);
      chk("full_start_pulses", 32'(obs_starts), 32'd1);
      chk("full_tx_held", spi_tx_byte, 32'hA1B2C3D4);

      // partial staggered, spurious lane 1, lane 0 pulsed twice
      sch_clear();
      sch_add(2, 0, 8'hAA);
      sch_add(4, 1, 8'hBB);
      sch_add(5, 0, 8'h5A);
      sch_add(9, 2, 8'hCC);
      issue(32'h0F0E0D0C, 4'b0101, a);
      pulses(10);
      wait_idle(60);
      chk("partial_latency", 32'(obs_first - a), 32'd11);
      chk("partial_rdata", obs_rd, 32'h00CC005A);
      chk("partial_err", 32'(obs_er), 32'd0);

      // zero mask with response back-pressure
      sch_clear();
      rsp_ready = 1'b0;
      issue(32'h12345678, 4'h0, a);
      repeat (3) begin
         @(posedge wb_clk_i);
         #1;
      end
      rsp_ready = 1'b1;
      wait_idle(20);
      chk("zero_latency", 32'(obs_first - a), 32'd1);
      chk("zero_rdata", obs_rd, 32'd0);
      chk("zero_start_pulses", 32'(obs_starts), 32'd0);
      chk("zero_valid_cycles", 32'(obs_rvn), 32'd4);
      chk("zero_tx_held", spi_tx_byte, 32'h12345678);

`ifdef SPRAID_TIMEOUT_EN
      // engine 3 never completes
      sch_clear();
      sch_add(3, 0, 8'h10);
      sch_add(3, 1, 8'h20);
      sch_add(3, 2, 8'h30);
      issue(32'hCAFEF00D, 4'hF, a);
      pulses(20);
      wait_idle(60);
      chk("tmo_latency", 32'(obs_first - a), 32'd18);
      chk("tmo_rdata", obs_rd, 32'h00302010);
      chk("tmo_err", 32'(obs_er), 32'd1);

      // engine 3 completes on the limit cycle
      sch_add(TO, 3, 8'h40);
      issue(32'hCAFEF00D, 4'hF, a);
      pulses(20);
      wait_idle(60);
      chk("limit_latency", 32'(obs_first - a), 32'd18);
      chk("limit_rdata", obs_rd, 32'h40302010);
      chk("limit_err", 32'(obs_err_fix(obs_er)), 32'd0);
`endif

      // reset three cycles after start, late done pulses follow
      sch_clear();
      sch_add(6, 0, 8'h01);
      sch_add(6, 1, 8'h02);
      sch_add(6, 2, 8'h03);
      sch_add(7, 3, 8'h04);
      hs0 = obs_hs;
      issue(32'h0BADF00D, 4'hF, a);
      fork
         pulses(8);
         begin
            repeat (3) @(posedge wb_clk_i);
            #1 wb_rst_i = 1'b1;
            repeat (2) @(posedge wb_clk_i);
            #1 wb_rst_i = 1'b0;
         end
      join
      chk("rst_no_response", 32'(obs_hs), 32'(hs0));
      chk("rst_tx_cleared", spi_tx_byte, 32'd0);

      // minimum latency after reset recovery
      sch_clear();
      sch_add(1, 0, 8'h01);
      sch_add(1, 1, 8'h02);
      sch_add(1, 2, 8'h03);
      sch_add(1, 3, 8'h04);
      issue(32'h55AA55AA, 4'hF, a);
      pulses(2);
      wait_idle(60);
      chk("min_latency", 32'(obs_first - a), 32'd3);
      chk("min_rdata", obs_rd, 32'h04030201);

      // upper lanes only, unmasked lane 0 pulses
      sch_clear();
      sch_add(1, 1, 8'h77);
      sch_add(1, 0, 8'hEE);
      sch_add(3, 3, 8'h99);
      issue(32'h89ABCDEF, 4'b1010, a);
      pulses(4);
      wait_idle(60);
      chk("odd_latency", 32'(obs_first - a), 32'd5);
      chk("odd_rdata", obs_rd, 32'h99007700);

      repeat (2) @(posedge wb_clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   function automatic logic obs_err_fix(input logic e);
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures",
               n_fail);
      $fatal(1, "watchdog");
   end

endmodule
